// File: rtl/wasm_linear_mem_if.sv
// Request/response bus between the wasm load/store unit (master) and linear memory (slave).
// One request in flight; req_ready low from acceptance until the response pulse has gone.
interface wasm_linear_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_trap;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_trap
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_trap
  );
endinterface

// File: rtl/wasm_linear_mem.sv
// Little-endian byte-addressed wasm linear memory over a 32-bit word RAM; latency load 3/4, store 2/3, trap 1.
// Single outstanding access: req_ready drops at acceptance and returns the cycle after rsp_valid.
module wasm_linear_mem #(
  parameter int ADDR_WIDTH       = 10,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic clk,
  input  logic rst,
  wasm_linear_mem_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_WR0  = 3'd4;
  localparam logic [2:0] S_WR1  = 3'd5;
  localparam logic [2:0] S_TRAP = 3'd6;

  localparam logic [32:0] MEM_BYTES = 33'd4 << ADDR_WIDTH;

  logic [2:0]            state;
  logic                  live;
  logic [ADDR_WIDTH-1:0] acc_word;
  logic [1:0]            acc_off;
  logic [1:0]            acc_size;
  logic                  acc_signed;
  logic                  acc_cross;
  logic [31:0]           acc_wdata;
  logic [31:0]           lo_word;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_trap_q;

  logic [2:0]  req_nb;
  logic [1:0]  req_misal;
  logic        req_oob;
  logic        req_trap;
  logic        req_cross;
  logic        accept;

  always_comb begin
    req_nb = 3'd4;
    case (bus.req_size)
      2'd0:    req_nb = 3'd1;
      2'd1:    req_nb = 3'd2;
      default: req_nb = 3'd4;
    endcase
  end

  // Low address bits that must be zero for a naturally aligned access of this size.
  assign req_misal = bus.req_addr[1:0] & {bus.req_size[1], bus.req_size[1] | bus.req_size[0]};
  assign req_oob   = ({1'b0, bus.req_addr} + {30'b0, req_nb}) > MEM_BYTES;
  assign req_trap  = (bus.req_size == 2'd3) || req_oob || (!ALLOW_MISALIGNED && (req_misal != 2'b00));
  assign req_cross = ({1'b0, bus.req_addr[1:0]} + req_nb) > 3'd4;

  assign bus.req_ready = live && (state == S_IDLE) && !rsp_valid_q;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_trap  = rsp_trap_q;

  logic [3:0]  size_mask;
  logic [7:0]  be_pair;
  logic [63:0] wd_pair;

  always_comb begin
    size_mask = 4'b1111;
    case (acc_size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Byte lanes 7:4 of the shifted enable/data belong to the following word.
  assign be_pair = {4'b0000, size_mask} << acc_off;
  assign wd_pair = {32'b0, acc_wdata} << {acc_off, 3'b000};

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wd;
  logic [31:0]           ram_dout;

  always_comb begin
    ram_addr = acc_word;
    ram_we   = 1'b0;
    ram_be   = be_pair[3:0];
    ram_wd   = wd_pair[31:0];
    case (state)
      S_RD1: ram_addr = acc_word + ADDR_WIDTH'(1);
      S_WR0: ram_we   = 1'b1;
      S_WR1: begin
        ram_addr = acc_word + ADDR_WIDTH'(1);
        ram_we   = 1'b1;
        ram_be   = be_pair[7:4];
        ram_wd   = wd_pair[63:32];
      end
      default: ;
    endcase
  end

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
      end
    end
    ram_dout <= mem[ram_addr];
  end

  logic [63:0] rd_pair;
  logic [31:0] rd_low;
  logic [31:0] load_ext;

  // In RESP the RAM output holds word w (non-crossing) or w+1 with w captured in lo_word.
  assign rd_pair = acc_cross ? {ram_dout, lo_word} : {32'b0, ram_dout};
  assign rd_low  = 32'(rd_pair >> {acc_off, 3'b000});

  always_comb begin
    load_ext = rd_low;
    case (acc_size)
      2'd0:    load_ext = {{24{acc_signed & rd_low[7]}}, rd_low[7:0]};
      2'd1:    load_ext = {{16{acc_signed & rd_low[15]}}, rd_low[15:0]};
      default: load_ext = rd_low;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      live        <= 1'b0;
      acc_word    <= '0;
      acc_off     <= 2'b00;
      acc_size    <= 2'b00;
      acc_signed  <= 1'b0;
      acc_cross   <= 1'b0;
      acc_wdata   <= 32'b0;
      lo_word     <= 32'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_trap_q  <= 1'b0;
    end else begin
      live        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_trap_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc_word   <= bus.req_addr[ADDR_WIDTH+1:2];
            acc_off    <= bus.req_addr[1:0];
            acc_size   <= bus.req_size;
            acc_signed <= bus.req_signed;
            acc_cross  <= req_cross;
            acc_wdata  <= bus.req_wdata;
            if (req_trap) begin
              state       <= S_TRAP;
              rsp_valid_q <= 1'b1;
              rsp_trap_q  <= 1'b1;
            end else begin
              state <= bus.req_we ? S_WR0 : S_RD0;
            end
          end
        end
        S_RD0: state <= acc_cross ? S_RD1 : S_RESP;
        S_RD1: begin
          lo_word <= ram_dout;
          state   <= S_RESP;
        end
        S_RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_ext;
          state       <= S_IDLE;
        end
        S_WR0: begin
          if (acc_cross) begin
            state <= S_WR1;
          end else begin
            rsp_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_WR1: begin
          rsp_valid_q <= 1'b1;
          state       <= S_IDLE;
        end
        S_TRAP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_linear_mem.sv
// Bench for wasm_linear_mem: one misaligned-capable and one aligned-only instance, table vectors plus
// hand sequences for back-to-back requests and reset in the middle of a crossing store.
module tb_wasm_linear_mem;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  wasm_linear_mem_if m0();
  wasm_linear_mem_if m1();

  wasm_linear_mem #(.ADDR_WIDTH(10), .ALLOW_MISALIGNED(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(m0));
  wasm_linear_mem #(.ADDR_WIDTH(10), .ALLOW_MISALIGNED(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(m1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          sel;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        trap;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        trap;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  vec_t tv[$];

  function automatic vec_t mk(int sel, bit we, int size, bit sgn, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, bit trap, int lat);
    vec_t v;
    v.sel = sel; v.we = we; v.size = 2'(size); v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.trap = trap; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m0.rsp_valid) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rsp0_unexpected got rdata=%h trap=%b", m0.rsp_rdata, m0.rsp_trap);
      end else begin
        e0 = q0.pop_front();
        if (m0.rsp_rdata !== e0.rdata || m0.rsp_trap !== e0.trap || (cyc - e0.acc) != e0.lat) begin
          errors++;
          $display("FAIL rsp0 id=%0d got rdata=%h trap=%b lat=%0d want rdata=%h trap=%b lat=%0d", e0.id,
                   m0.rsp_rdata, m0.rsp_trap, cyc - e0.acc, e0.rdata, e0.trap, e0.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m1.rsp_valid) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rsp1_unexpected got rdata=%h trap=%b", m1.rsp_rdata, m1.rsp_trap);
      end else begin
        e1 = q1.pop_front();
        if (m1.rsp_rdata !== e1.rdata || m1.rsp_trap !== e1.trap || (cyc - e1.acc) != e1.lat) begin
          errors++;
          $display("FAIL rsp1 id=%0d got rdata=%h trap=%b lat=%0d want rdata=%h trap=%b lat=%0d", e1.id,
                   m1.rsp_rdata, m1.rsp_trap, cyc - e1.acc, e1.rdata, e1.trap, e1.lat);
        end
      end
    end
  end

  task automatic drive(input int sel, input vec_t v);
    if (sel == 0) begin
      m0.req_valid = 1'b1; m0.req_we = v.we; m0.req_size = v.size; m0.req_signed = v.sgn;
      m0.req_addr = v.addr; m0.req_wdata = v.wdata;
    end else begin
      m1.req_valid = 1'b1; m1.req_we = v.we; m1.req_size = v.size; m1.req_signed = v.sgn;
      m1.req_addr = v.addr; m1.req_wdata = v.wdata;
    end
  endtask

  task automatic push(input int sel, input vec_t v, input int id);
    exp_t e;
    e.rdata = v.rdata; e.trap = v.trap; e.lat = v.lat; e.acc = cyc; e.id = id;
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_ready(input int sel, input int id, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!((sel == 0) ? m0.req_ready : m1.req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout id=%0d got req_ready=0 want 1 within 50 cycles", id);
    end
  endtask

  task automatic issue(input int sel, input vec_t v, input int id, input bit track);
    bit ok;
    wait_ready(sel, id, ok);
    if (ok) begin
      drive(sel, v);
      if (track) push(sel, v, id);
      @(posedge clk);
      #1;
      m0.req_valid = 1'b0;
      m1.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int sel, input int id);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #2;
      if (((sel == 0) ? q0.size() : q1.size()) == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL rsp_timeout id=%0d got no response want one within 50 cycles", id);
    if (sel == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic run(input vec_t v, input int id);
    issue(v.sel, v, id, 1'b1);
    wait_done(v.sel, id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   ok;
    bit   seen;

    rst = 1'b1;
    m0.req_valid = 1'b0; m0.req_we = 1'b0; m0.req_size = 2'd0; m0.req_signed = 1'b0;
    m0.req_addr = 32'h0; m0.req_wdata = 32'h0;
    m1.req_valid = 1'b0; m1.req_we = 1'b0; m1.req_size = 2'd0; m1.req_signed = 1'b0;
    m1.req_addr = 32'h0; m1.req_wdata = 32'h0;

    //        sel we sz sg addr          wdata         rdata         trap lat
    tv.push_back(mk(0, 1, 2, 0, 32'h0000000C, 32'hCAFEF00D, 32'h00000000, 0, 2));
    tv.push_back(mk(0, 1, 2, 0, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 0, 2));
    tv.push_back(mk(0, 0, 2, 0, 32'h00000010, 32'h0,        32'hDEADBEEF, 0, 3));
    tv.push_back(mk(0, 0, 0, 1, 32'h00000013, 32'h0,        32'hFFFFFFDE, 0, 3));
    tv.push_back(mk(0, 0, 0, 0, 32'h00000013, 32'h0,        32'h000000DE, 0, 3));
    tv.push_back(mk(0, 0, 1, 1, 32'h00000010, 32'h0,        32'hFFFFBEEF, 0, 3));
    tv.push_back(mk(0, 1, 2, 0, 32'h0000000E, 32'h11223344, 32'h00000000, 0, 3));
    tv.push_back(mk(0, 0, 2, 0, 32'h0000000E, 32'h0,        32'h11223344, 0, 4));
    tv.push_back(mk(0, 0, 2, 0, 32'h0000000C, 32'h0,        32'h3344F00D, 0, 3));
    tv.push_back(mk(0, 0, 2, 0, 32'h00000010, 32'h0,        32'hDEAD1122, 0, 3));
    tv.push_back(mk(0, 0, 1, 0, 32'h0000000F, 32'h0,        32'h00002233, 0, 4));
    tv.push_back(mk(0, 0, 0, 1, 32'h0000000D, 32'h0,        32'hFFFFFFF0, 0, 3));
    tv.push_back(mk(0, 1, 2, 0, 32'h00000FFC, 32'h01020304, 32'h00000000, 0, 2));
    tv.push_back(mk(0, 0, 2, 0, 32'h00000FFC, 32'h0,        32'h01020304, 0, 3));
    tv.push_back(mk(0, 0, 2, 0, 32'h00000FFD, 32'h0,        32'h00000000, 1, 1));
    tv.push_back(mk(0, 0, 1, 0, 32'hFFFFFFFE, 32'h0,        32'h00000000, 1, 1));
    tv.push_back(mk(0, 1, 2, 0, 32'h00000FFD, 32'hFFFFFFFF, 32'h00000000, 1, 1));
    tv.push_back(mk(0, 1, 1, 0, 32'h00000FFF, 32'hFFFFFFFF, 32'h00000000, 1, 1));
    tv.push_back(mk(0, 0, 2, 0, 32'h00000FFC, 32'h0,        32'h01020304, 0, 3));
    tv.push_back(mk(0, 0, 0, 0, 32'h00000FFF, 32'h0,        32'h00000001, 0, 3));
    tv.push_back(mk(0, 1, 0, 0, 32'h00000FFF, 32'h000000AB, 32'h00000000, 0, 2));
    tv.push_back(mk(0, 0, 2, 0, 32'h00000FFC, 32'h0,        32'hAB020304, 0, 3));
    tv.push_back(mk(0, 0, 3, 0, 32'h00000000, 32'h0,        32'h00000000, 1, 1));
    tv.push_back(mk(0, 1, 1, 0, 32'h00000011, 32'hFFFF9988, 32'h00000000, 0, 2));
    tv.push_back(mk(0, 0, 2, 0, 32'h00000010, 32'h0,        32'hDE998822, 0, 3));
    tv.push_back(mk(0, 0, 1, 1, 32'h00000011, 32'h0,        32'hFFFF9988, 0, 3));
    tv.push_back(mk(0, 1, 1, 0, 32'h00000013, 32'h00007766, 32'h00000000, 0, 3));
    tv.push_back(mk(0, 0, 1, 0, 32'h00000013, 32'h0,        32'h00007766, 0, 4));
    tv.push_back(mk(0, 0, 2, 0, 32'h00000010, 32'h0,        32'h66998822, 0, 3));
    tv.push_back(mk(0, 1, 2, 0, 32'h0000001C, 32'hAAAAAAAA, 32'h00000000, 0, 2));
    tv.push_back(mk(0, 1, 2, 0, 32'h00000020, 32'hBBBBBBBB, 32'h00000000, 0, 2));
    tv.push_back(mk(1, 1, 2, 0, 32'h00000020, 32'h55667788, 32'h00000000, 0, 2));
    tv.push_back(mk(1, 0, 1, 0, 32'h00000021, 32'h0,        32'h00000000, 1, 1));
    tv.push_back(mk(1, 0, 3, 0, 32'h00000020, 32'h0,        32'h00000000, 1, 1));
    tv.push_back(mk(1, 1, 2, 0, 32'h00000022, 32'h00000000, 32'h00000000, 1, 1));
    tv.push_back(mk(1, 0, 1, 0, 32'h00000022, 32'h0,        32'h00005566, 0, 3));
    tv.push_back(mk(1, 0, 2, 0, 32'h00000020, 32'h0,        32'h55667788, 0, 3));
    tv.push_back(mk(1, 1, 0, 0, 32'h00000023, 32'h00000099, 32'h00000000, 0, 2));
    tv.push_back(mk(1, 0, 2, 0, 32'h00000020, 32'h0,        32'h99667788, 0, 3));

    repeat (2) @(negedge clk);
    chk("rst_ready0",     32'(m0.req_ready), 32'h0);
    chk("rst_ready1",     32'(m1.req_ready), 32'h0);
    chk("rst_rsp_valid0", 32'(m0.rsp_valid), 32'h0);
    chk("rst_rsp_rdata0", m0.rsp_rdata,      32'h0);
    chk("rst_rsp_trap0",  32'(m0.rsp_trap),  32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready0", 32'(m0.req_ready), 32'h1);
    chk("post_rst_ready1", 32'(m1.req_ready), 32'h1);

    for (int i = 0; i < tv.size(); i++) run(tv[i], i);

    // Back-to-back on the aligned-only instance: valid held high across two requests.
    v = mk(1, 0, 2, 0, 32'h00000020, 32'h0, 32'h99667788, 0, 3);
    wait_ready(1, 100, ok);
    if (ok) begin
      drive(1, v);
      push(1, v, 100);
      @(posedge clk);
      #1;
      v = mk(1, 0, 1, 0, 32'h00000020, 32'h0, 32'h00007788, 0, 3);
      drive(1, v);
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        chk("b2b_ready_low", 32'(m1.req_ready), 32'h0);
        seen = m1.rsp_valid;
      end
      chk("b2b_rsp_seen", 32'(seen), 32'h1);
      @(negedge clk);
      chk("b2b_ready_after_rsp", 32'(m1.req_ready), 32'h1);
      push(1, v, 101);
      @(posedge clk);
      #1;
      m1.req_valid = 1'b0;
      wait_done(1, 101);
    end

    // Reset while the crossing store to 0x1E is in WR1: only word 0x1C takes the new bytes.
    v = mk(0, 1, 2, 0, 32'h0000001E, 32'h12345678, 32'h0, 0, 3);
    issue(0, v, 200, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(m0.rsp_valid), 32'h0);
    chk("midrst_rsp_rdata", m0.rsp_rdata,      32'h0);
    chk("midrst_rsp_trap",  32'(m0.rsp_trap),  32'h0);
    chk("midrst_ready",     32'(m0.req_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready_after", 32'(m0.req_ready), 32'h1);
    run(mk(0, 0, 2, 0, 32'h0000001C, 32'h0, 32'h5678AAAA, 0, 3), 201);
    run(mk(0, 0, 2, 0, 32'h00000020, 32'h0, 32'hBBBBBBBB, 0, 3), 202);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
